data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder_pkg.sv | 29 ++
 rtl/data_memory_responder_store_merge.sv | 49 ++++
 rtl/data_memory_responder.sv | 183 ++++++++++++++++++
 tb/tb_data_memory_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared types for the data memory responder: request bundle,
// store width, access direction and the responder FSM state.
package data_memory_responder_pkg;

  typedef enum logic {
    MEM_READ_EN  = 1'b0,
    MEM_WRITE_EN = 1'b1
  } mem_en_t;

  typedef enum logic [1:0] {
    STORE_BYTE  = 2'd0,
    STORE_HBYTE = 2'd1,
    STORE_WORD  = 2'd2
  } store_op_t;

  typedef struct packed {
    logic        mem_enable;
    mem_en_t     mem_en;
    logic [31:0] address;
    logic [31:0] data_in;
  } data_memory_interface_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/data_memory_responder_store_merge.sv
// dmem_store_merge: byte-lane write merge of right-aligned store data.
// Ports: old_word, data_in, store_op, addr_lo in; new_word out.
module dmem_store_merge
  import data_memory_responder_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data_in,
  input  store_op_t   store_op,
  input  logic [1:0]  addr_lo,
  output logic [31:0] new_word
);

  logic [3:0]  lane_en;
  logic [31:0] lane_data;

  always_comb begin
    lane_en   = 4'b0000;
    lane_data = old_word;
    unique case (store_op)
      STORE_WORD: begin
        lane_en   = 4'b1111;
        lane_data = data_in;
      end
      STORE_HBYTE: begin
        // address[0] is ignored: the pair is picked by address[1]
        lane_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{data_in[15:0]}};
      end
      STORE_BYTE: begin
        lane_en   = 4'b0001 << addr_lo;
        lane_data = {4{data_in[7:0]}};
      end
      default: begin
        lane_en   = 4'b0000;
        lane_data = old_word;
      end
    endcase
  end

  always_comb begin
    new_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        new_word[8*i +: 8] = lane_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: single-outstanding word-array slave with a
// fixed WAIT_CYCLES response delay and byte-lane store merging.
// Ports: clock, reset_n (async, active low); memory_signals and
// store_op request; mem_data_out, mem_ready, busy, mem_error response.
// Option: DMEM_MISALIGN_CHECK_EN raises mem_error on misaligned
// writes and out-of-range accesses; otherwise mem_error is tied 0.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  data_memory_interface_t memory_signals,
  input  store_op_t              store_op,
  output logic [31:0]            mem_data_out,
  output logic                   mem_ready,
  output logic                   busy,
  output logic                   mem_error
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_t state;
  dmem_state_t state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;

  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  store_op_t   req_op;

  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_data;
  store_op_t   acc_op;

  logic [29:0]   acc_idx;
  logic [AW-1:0] slot;
  logic          in_range;
  logic          fault;
  logic          accept;
  logic          enter_resp;
  logic          wr_en;
  logic [31:0]   old_word;
  logic [31:0]   new_word;
  logic [31:0]   rd_word;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept = (state == IDLE) && memory_signals.mem_enable;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (memory_signals.mem_enable) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // The access is committed on the edge entering RESP, so a direct
  // IDLE->RESP hop (no wait) must use the live request fields.
  always_comb begin
    acc_write = req_write;
    acc_addr  = req_addr;
    acc_data  = req_data;
    acc_op    = req_op;
    if (state == IDLE) begin
      acc_write = (memory_signals.mem_en == MEM_WRITE_EN);
      acc_addr  = memory_signals.address;
      acc_data  = memory_signals.data_in;
      acc_op    = store_op;
    end
  end

  assign acc_idx    = acc_addr[31:2];
  assign slot       = acc_idx[AW-1:0];
  assign in_range   = {2'b00, acc_idx} < 32'(DEPTH_WORDS);
  assign enter_resp = (state != RESP) && (state_nx == RESP);
  assign old_word   = in_range ? mem[slot] : 32'd0;
  assign rd_word    = (in_range && !fault) ? old_word : 32'd0;

  // reset_n gates the write so a reset held across an edge can
  // never commit an abandoned request
  assign wr_en = reset_n && enter_resp && acc_write
              && in_range && !fault;

  dmem_store_merge u_merge (
    .old_word (old_word),
    .data_in  (acc_data),
    .store_op (acc_op),
    .addr_lo  (acc_addr[1:0]),
    .new_word (new_word)
  );

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[slot] <= new_word;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      busy         <= 1'b0;
      mem_ready    <= 1'b0;
      mem_data_out <= 32'd0;
      req_write    <= 1'b0;
      req_addr     <= 32'd0;
      req_data     <= 32'd0;
      req_op       <= STORE_BYTE;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      busy      <= (state_nx != IDLE);
      mem_ready <= enter_resp;
      if (accept) begin
        req_write <= (memory_signals.mem_en == MEM_WRITE_EN);
        req_addr  <= memory_signals.address;
        req_data  <= memory_signals.data_in;
        req_op    <= store_op;
      end
      if (enter_resp && !acc_write) begin
        mem_data_out <= rd_word;
      end
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  // width alignment only matters for stores; loads always fetch
  // the whole aligned word
  always_comb begin
    fault = !in_range;
    if (acc_write) begin
      unique case (acc_op)
        STORE_HBYTE: fault = fault || acc_addr[0];
        STORE_WORD:  fault = fault || (acc_addr[1:0] != 2'b00);
        default:     fault = fault;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_error <= 1'b0;
    end else begin
      mem_error <= enter_resp && fault;
    end
  end
`else
  assign fault     = 1'b0;
  assign mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed + randomized bench for data_memory_responder against a
// byte-addressed reference memory.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam int DEPTH = 1024;
  localparam int WAITC = 1;
  localparam int NBYTES = 4 * DEPTH;

  logic                   clock;
  logic                   reset_n;
  data_memory_interface_t ms;
  store_op_t              sop;
  logic [31:0]            mem_data_out;
  logic                   mem_ready;
  logic                   busy;
  logic                   mem_error;

  int          vectors;
  int          miscompares;
  logic [31:0] rd;
  logic [31:0] last_rd;
  logic [7:0]  mb [NBYTES];
  int          last;
  int          pulses;

  data_memory_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .memory_signals (ms),
    .store_op       (sop),
    .mem_data_out   (mem_data_out),
    .mem_ready      (mem_ready),
    .busy           (busy),
    .mem_error      (mem_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_fault(input logic wr,
                                       input logic [31:0] a,
                                       input store_op_t op);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (a >= 32'(NBYTES)) return 1'b1;
    if (!wr) return 1'b0;
    if (op == STORE_HBYTE) return a[0];
    if (op == STORE_WORD) return (a[1:0] != 2'b00);
    return 1'b0;
`else
    return wr & a[0] & (op == STORE_WORD) & 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int b;
    if (a >= 32'(NBYTES)) return 32'd0;
    b = int'(a) & ~3;
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  function automatic void model_write(input logic [31:0] a,
                                      input logic [31:0] d,
                                      input store_op_t op);
    int b;
    int n;
    if (a >= 32'(NBYTES)) return;
    case (op)
      STORE_WORD:  begin b = int'(a) & ~3; n = 4; end
      STORE_HBYTE: begin b = int'(a) & ~1; n = 2; end
      default:     begin b = int'(a);      n = 1; end
    endcase
    for (int i = 0; i < n; i++) mb[b+i] = d[8*i +: 8];
  endfunction

  task automatic req(input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input store_op_t op,
                     output logic [31:0] rdata, output int lat,
                     output logic err, output logic bsy);
    @(negedge clock);
    ms.mem_enable = 1'b1;
    ms.mem_en     = wr ? MEM_WRITE_EN : MEM_READ_EN;
    ms.address    = a;
    ms.data_in    = d;
    sop           = op;
    @(posedge clock); #1;
    ms.mem_enable = 1'b0;
    bsy   = busy;
    lat   = 0;
    err   = 1'bx;
    rdata = 32'hxxxxxxxx;
    for (int k = 1; k <= 20; k++) begin
      if (mem_ready) begin
        lat   = k;
        err   = mem_error;
        rdata = mem_data_out;
        break;
      end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
  endtask

  task automatic access(input string tag, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input store_op_t op);
    logic [31:0] exp_d;
    logic        exp_e;
    int          lat;
    logic        e;
    logic        b;
    exp_e = model_fault(wr, a, op);
    exp_d = wr ? last_rd : (exp_e ? 32'd0 : model_read(a));
    req(wr, a, d, op, rd, lat, e, b);
    check({tag, "_busy"}, 32'(b), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(WAITC + 1));
    check({tag, "_err"}, 32'(e), 32'(exp_e));
    check({tag, "_data"}, rd, exp_d);
    if (wr && !exp_e) model_write(a, d, op);
    last_rd = exp_d;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ms          = '0;
    sop         = STORE_WORD;
    reset_n     = 1'b0;
    last_rd     = 32'd0;
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;

    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_err", 32'(mem_error), 32'd0);
    check("rst_data", mem_data_out, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    access("w10", 1'b1, 32'h10, 32'hDEADBEEF, STORE_WORD);
    access("r10", 1'b0, 32'h10, 32'h0, STORE_WORD);
    check("word_rd", rd, 32'hDEADBEEF);
    access("w14", 1'b1, 32'h14, 32'h01020304, STORE_WORD);
    check("wr_hold", mem_data_out, 32'hDEADBEEF);

    access("w20", 1'b1, 32'h20, 32'h11223344, STORE_WORD);
    access("b23", 1'b1, 32'h23, 32'h000000AA, STORE_BYTE);
    access("r20a", 1'b0, 32'h20, 32'h0, STORE_WORD);
    check("byte_merge", rd, 32'hAA223344);
    access("h22", 1'b1, 32'h22, 32'h0000BEEF, STORE_HBYTE);
    access("r20b", 1'b0, 32'h20, 32'h0, STORE_WORD);
    check("half_merge", rd, 32'hBEEF3344);

    access("w0", 1'b1, 32'h0, 32'h12345678, STORE_WORD);
    access("woor", 1'b1, 32'h1000, 32'hCAFEF00D, STORE_WORD);
    access("r0", 1'b0, 32'h0, 32'h0, STORE_WORD);
    check("oor_drop", rd, 32'h12345678);
    access("roor", 1'b0, 32'h1000, 32'h0, STORE_WORD);
    check("oor_read", rd, 32'd0);

    access("w40", 1'b1, 32'h40, 32'h0, STORE_WORD);
    access("w41", 1'b1, 32'h41, 32'h9ABCDEF0, STORE_WORD);
    access("r40", 1'b0, 32'h40, 32'h0, STORE_WORD);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("mis_word", rd, 32'd0);
`else
    check("mis_word", rd, 32'h9ABCDEF0);
`endif

    @(negedge clock);
    ms.mem_enable = 1'b1;
    ms.mem_en     = MEM_READ_EN;
    ms.address    = 32'h10;
    sop           = STORE_WORD;
    last   = -1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      if (mem_ready) begin
        if (last >= 0) check("b2b_gap", 32'(c - last), 32'(WAITC + 2));
        check("b2b_data", mem_data_out, model_read(32'h10));
        last = c;
        pulses++;
      end
    end
    ms.mem_enable = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd4);
    last_rd = model_read(32'h10);

    access("w40z", 1'b1, 32'h40, 32'h0, STORE_WORD);
    @(negedge clock);
    ms.mem_enable = 1'b1;
    ms.mem_en     = MEM_WRITE_EN;
    ms.address    = 32'h40;
    ms.data_in    = 32'h55555555;
    sop           = STORE_WORD;
    @(posedge clock); #1;
    ms.mem_enable = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(mem_ready), 32'd0);
    check("mid_rst_err", 32'(mem_error), 32'd0);
    check("mid_rst_data", mem_data_out, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    last_rd = 32'd0;
    access("r40z", 1'b0, 32'h40, 32'h0, STORE_WORD);
    check("abandon", rd, 32'd0);

    for (int w = 0; w < 16; w++) begin
      access("init", 1'b1, 32'h100 + 32'(4 * w), $urandom, STORE_WORD);
    end
    for (int n = 0; n < 60; n++) begin
      logic        wr;
      logic [31:0] a;
      store_op_t   op;
      wr = 1'($urandom_range(0, 1));
      a  = 32'h100 + 32'($urandom_range(0, 63));
      op = store_op_t'(2'($urandom_range(0, 2)));
      access("rnd", wr, a, $urandom, op);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
